spi_slave_txrx: RTL and testbench
=================================

Name: spi_slave_txrx

Overview:
- System-clocked SPI slave for the return path: drives MISO with a host-loaded byte while capturing MOSI.
- Sits beside the existing SCLK-domain slave receiver and talks to the existing master through the same sclk/cs/mosi wires.
- Oversamples sclk, cs and mosi with the system clock, so there is no logic in the SCLK domain.
- Protocol is fixed. MSB first. The transmitter changes data on sclk rising; the receiver samples on sclk falling. cs is active-low.

Parameters:
- DATA_W, 8, frame width in bits.
- SYNC_STAGES, 2, synchroniser depth for sclk, cs and mosi (minimum 2).
- FILL, 8'h00, byte shifted out when no tx byte is loaded (underrun).

Ports:
- clk  in  1  system clock; sclk must be at most clk/8.
- rst  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from the master (asynchronous).
- cs  in  1  chip select from the master, active-low (asynchronous).
- mosi  in  1  serial data from the master (asynchronous).
- miso  out  1  serial data to the master.
- tx_data  in  DATA_W  byte to send in the next frame.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-entry tx buffer empty; a load happens when tx_valid && tx_ready.
- rx_data  out  DATA_W  last completed received byte; held until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- underrun  out  1  one-cycle pulse when a frame starts with the tx buffer empty.
- abort  out  1  one-cycle pulse when cs rises before DATA_W bits are received.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE.
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, abort=0, busy=0.
  - Buffer empty; shift registers and counters cleared.
  - Synchroniser flops reset to sclk=0, cs=1, mosi=0.
- Reset mid-frame discards the frame with no abort pulse. The slave re-arms on the next cs falling edge seen after reset release.
- Edge detect: compare the last synchroniser stage with one extra delayed flop.
  - Events are sclk_rise, sclk_fall, cs_fall and cs_rise, each one clk wide.
  - Latency from a pin edge to its event is SYNC_STAGES+1 clk.
- Buffer: tx_ready = !buf_full.
  - A load sets buf_full on the next clk.
  - A load with tx_ready=0 is ignored.
- States:
  - IDLE:
    - miso=0.
    - On cs_fall, go to SHIFT with tx_cnt=0 and rx_cnt=0.
    - If buf_full: tx_shift<=buffer and the buffer is emptied in the same cycle.
    - Else: tx_shift<=FILL and underrun pulses.
    - A tx load in the cs_fall cycle while the buffer is empty fills the buffer for the next frame, not this one.
  - SHIFT:
    - On sclk_rise with tx_cnt<DATA_W: miso<=tx_shift[DATA_W-1], tx_shift shifts left, tx_cnt++.
    - On sclk_fall with rx_cnt<DATA_W: rx_shift<={rx_shift[DATA_W-2:0], mosi_sync}, rx_cnt++.
    - When rx_cnt reaches DATA_W, the next clk sets rx_data<=rx_shift, pulses rx_valid and moves to END.
    - cs_rise before that point: pulse abort, miso<=0, go to IDLE, leave rx_data unchanged.
  - END:
    - miso=0.
    - sclk edges are ignored.
    - cs_rise moves to IDLE.
    - A cs_fall without an intervening cs_rise is impossible and is ignored.
- Simultaneous events:
  - cs_rise in the same clk as the final sclk_fall: the frame completes (rx_valid pulses), then the state goes to IDLE without an abort.
  - sclk_rise and cs_rise in the same clk: cs_rise wins.
- Counters are $clog2(DATA_W+1) bits wide and never wrap.
- miso is registered, with no combinational path from any input.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, END} spi_slv_state_t.
  - Constant SPI_SYNC_DEFAULT=2.
- Sub-module spi_sync_edge (SYNC_STAGES, RST_VAL) provides the synchroniser plus rise/fall detect.
  - Instantiated three times.
  - The mosi instance uses only its synchronised output.

Test Plan:
- Basic frame:
  - Stimulus: load 8'hA5, then the master (sclk = clk/8) sends 8'hEF.
  - Response: miso bits after successive sclk rises are 1,0,1,0,0,1,0,1. rx_data=8'hEF, rx_valid high exactly 1 clk, tx_ready returns to 1 at frame start, no underrun or abort.
- Underrun:
  - Stimulus: frame with no load, FILL=8'h00, master sends 8'h3C.
  - Response: underrun pulses once at cs_fall, miso stays 0 all frame, rx_data=8'h3C.
- Abort:
  - Stimulus: load 8'hF0, cs rises after 3 sclk falls.
  - Response: abort pulses once, no rx_valid, rx_data keeps its prior value, state returns to IDLE, miso=0.
  - Follow-up: the next frame with 8'h81 loaded completes correctly.
- Back-to-back frames:
  - Stimulus: load 8'h12, start a frame, load 8'h34 mid-frame (tx_ready=1 after frame start), then a second frame follows.
  - Response: miso sends 8'h12 then 8'h34. A third load attempted while the buffer is full is ignored.
- Extra clocks:
  - Stimulus: master gives 10 sclk cycles with cs low.
  - Response: exactly 8 bits are captured, one rx_valid, miso=0 after bit 8, cs_rise returns the state to IDLE.
- Reset mid-frame:
  - Stimulus: rst=0 for 2 clk after 4 bits.
  - Response: all outputs are at reset values, no abort or rx_valid, buffer empty.
  - Follow-up: the next full frame works.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the system-clocked SPI slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    END
  } spi_slv_state_t;

  localparam int SPI_SYNC_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin.
// Produces one-clk rise/fall events against a delayed copy.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SPI_SYNC_DEFAULT,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~dly_q;
  assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_slave_txrx.sv
// SPI slave, MSB first: miso changes on sclk rise, mosi sampled on sclk fall.
// All pins are oversampled by clk; no logic runs in the sclk domain.
module spi_slave_txrx
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = SPI_SYNC_DEFAULT,
  parameter logic [DATA_W-1:0] FILL        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              abort,
  output logic              busy
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic mosi_s;
  logic sclk_unused_lvl, cs_unused_lvl;
  logic mosi_unused_rise, mosi_unused_fall;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_sclk (
    .clk (clk),
    .rst (rst),
    .din (sclk),
    .dout(sclk_unused_lvl),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_cs (
    .clk (clk),
    .rst (rst),
    .din (cs),
    .dout(cs_unused_lvl),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_mosi (
    .clk (clk),
    .rst (rst),
    .din (mosi),
    .dout(mosi_s),
    .rise(mosi_unused_rise),
    .fall(mosi_unused_fall)
  );

  spi_slv_state_t    state;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [CW-1:0]     tx_cnt;
  logic [CW-1:0]     rx_cnt;
  logic              last_fall;

  assign rx_next   = {rx_shift[DATA_W-2:0], mosi_s};
  assign last_fall = sclk_fall && (rx_cnt == LAST_CNT);
  assign tx_ready  = !buf_full;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      buf_q    <= '0;
      buf_full <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      if (tx_valid && !buf_full) begin
        buf_q    <= tx_data;
        buf_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state    <= SHIFT;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            rx_shift <= '0;
            if (buf_full) begin
              tx_shift <= buf_q;
              buf_full <= 1'b0;
            end else begin
              tx_shift <= FILL;
              underrun <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            // A final sample landing with cs_rise still completes the frame.
            miso  <= 1'b0;
            state <= IDLE;
            if (rx_cnt == FULL_CNT) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else if (last_fall) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              rx_cnt   <= FULL_CNT;
            end else begin
              abort <= 1'b1;
            end
          end else if (rx_cnt == FULL_CNT) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            miso     <= 1'b0;
            state    <= END;
          end else begin
            if (sclk_rise && tx_cnt < FULL_CNT) begin
              miso     <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              tx_cnt   <= tx_cnt + 1'b1;
            end
            if (sclk_fall) begin
              rx_shift <= rx_next;
              rx_cnt   <= rx_cnt + 1'b1;
            end
          end
        end
        END: begin
          miso <= 1'b0;
          if (cs_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_txrx.sv
// Scoreboard bench: master model drives frames, monitor checks rx bytes.
module tb_spi_slave_txrx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, tx_ready, rx_valid, underrun, abort, busy;
  logic [7:0] rx_data;

  localparam logic [7:0] FILL = 8'h00;

  spi_slave_txrx #(
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .FILL       (FILL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .underrun(underrun),
    .abort   (abort),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mbuf[$];
  logic [7:0] last_rx = 8'h00;
  int n_under = 0, n_abort = 0;
  int exp_under = 0, exp_abort = 0;
  logic prev_rxv = 1'b0;
  logic [7:0] mon_e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        chk("rx_valid_width", 32'(prev_rxv), 32'd0);
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(mon_e));
        end
      end
      if (underrun) n_under++;
      if (abort) n_abort++;
    end
    prev_rxv = rx_valid;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(logic [7:0] d);
    @(negedge clk);
    chk("tx_ready_load", 32'(tx_ready), 32'(mbuf.size() == 0));
    tx_data  = d;
    tx_valid = 1'b1;
    if (mbuf.size() == 0) mbuf.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  // nclk sclk cycles; fewer than 8 means cs rises early (abort).
  // rst_at >= 0 resets the DUT once that many bits have been sent.
  task automatic frame(logic [7:0] mo, int nclk, bit do_mid,
                       logic [7:0] mid, int rst_at);
    logic [7:0] txb;
    cyc(1);
    if (mbuf.size() != 0) begin
      txb = mbuf.pop_front();
    end else begin
      txb = FILL;
      exp_under++;
    end
    if (rst_at < 0) begin
      if (nclk >= 8) begin
        rx_q.push_back(mo);
        last_rx = mo;
      end else begin
        exp_abort++;
      end
    end
    cs = 1'b0;
    cyc(8);
    chk("busy_start", 32'(busy), 32'd1);
    chk("tx_ready_start", 32'(tx_ready), 32'(mbuf.size() == 0));
    for (int i = 0; i < nclk; i++) begin
      if (rst_at == i) begin
        rst  = 1'b0;
        cs   = 1'b1;
        sclk = 1'b0;
        mbuf.delete();
        last_rx = 8'h00;
        cyc(2);
        chk_reset_outs();
        rst = 1'b1;
        cyc(8);
        chk("rst_busy_after", 32'(busy), 32'd0);
        chk("rst_abort_cnt", 32'(n_abort), 32'(exp_abort));
        return;
      end
      sclk = 1'b1;
      mosi = (i < 8) ? mo[7-i] : 1'($urandom);
      cyc(4);
      chk("miso_bit", 32'(miso), 32'((i < 8) ? txb[7-i] : 1'b0));
      sclk = 1'b0;
      cyc(4);
      if (do_mid && i == 3) load(mid);
    end
    cyc(2);
    cs = 1'b1;
    cyc(8);
    chk("busy_end", 32'(busy), 32'd0);
    chk("miso_idle", 32'(miso), 32'd0);
    chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
    chk("rx_data_hold", 32'(rx_data), 32'(last_rx));
    chk("underrun_cnt", 32'(n_under), 32'(exp_under));
    chk("abort_cnt", 32'(n_abort), 32'(exp_abort));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    rst = 1'b0;
    cyc(3);
    chk_reset_outs();
    rst = 1'b1;
    cyc(4);

    load(8'hA5);
    frame(8'hEF, 8, 1'b0, 8'h00, -1);

    frame(8'h3C, 8, 1'b0, 8'h00, -1);

    load(8'hF0);
    frame(8'h6B, 3, 1'b0, 8'h00, -1);
    load(8'h81);
    frame(8'h81, 8, 1'b0, 8'h00, -1);

    load(8'h12);
    frame(8'h55, 8, 1'b1, 8'h34, -1);
    load(8'h56);
    frame(8'hAA, 8, 1'b0, 8'h00, -1);

    load(8'hC3);
    frame(8'h99, 10, 1'b0, 8'h00, -1);

    load(8'h7E);
    frame(8'h66, 8, 1'b0, 8'h00, 4);
    load(8'h5A);
    frame(8'hB4, 8, 1'b0, 8'h00, -1);

    repeat (20) begin
      if ($urandom_range(0, 2) != 0) load(8'($urandom));
      r = $urandom_range(0, 9);
      if (r < 2) begin
        frame(8'($urandom), $urandom_range(1, 7), 1'b0, 8'h00, -1);
      end else begin
        frame(8'($urandom), $urandom_range(8, 10),
              1'($urandom), 8'($urandom), -1);
      end
    end

    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
